// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
// Shared processor constants and types. The writeback, decode and hazard
// logic all use these so that register indices and data words have a single
// definition.
//   DATA_W   : register / datapath width
//   ADDR_W   : register index width
//   NREGS    : number of architectural registers (2**ADDR_W)
//   ZERO_REG : index of the hardwired-zero register
// ---------------------------------------------------------------------------
package proc_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_addr_t ZERO_REG = 5'd0;
endpackage

// File: rtl/reg_file_if.sv
// ---------------------------------------------------------------------------
// reg_file_if
// Bundles the writeback-side write port, the two decode-side read ports and
// the write counter of the register file.
//   RegWriteW / WriteRegW / ResultW : write enable, index and data (writeback)
//   A1 / A2                         : read indices (decode)
//   RD1 / RD2                       : read data, combinational
//   wr_count                        : committed writes to non-zero registers
// Modports:
//   master : pipeline side, drives write and read-index signals
//   slave  : register file side, returns read data and the counter
// There is no valid/ready handshake: a write is taken on every rising clock
// edge where RegWriteW is high, and reads are pure combinational lookups.
// ---------------------------------------------------------------------------
interface reg_file_if;
  logic                RegWriteW;
  proc_pkg::reg_addr_t WriteRegW;
  proc_pkg::word_t     ResultW;
  proc_pkg::reg_addr_t A1;
  proc_pkg::reg_addr_t A2;
  proc_pkg::word_t     RD1;
  proc_pkg::word_t     RD2;
  logic [15:0]         wr_count;

  modport master (
    output RegWriteW, WriteRegW, ResultW, A1, A2,
    input  RD1, RD2, wr_count
  );

  modport slave (
    input  RegWriteW, WriteRegW, ResultW, A1, A2,
    output RD1, RD2, wr_count
  );
endinterface

// File: rtl/reg_file_rd_port.sv
// ---------------------------------------------------------------------------
// reg_file_rd_port
// One combinational read port of the register file.
//   i_rst   : reset; forces the output to zero and blocks the bypass
//   i_addr  : read index
//   i_we    : write enable of the same-cycle write
//   i_waddr : index of the same-cycle write
//   i_wdata : data of the same-cycle write
//   i_regs  : committed register contents
//   o_data  : read data
// Priority: index 0 -> 0, then same-cycle write (write-first bypass), then
// the stored value.
// ---------------------------------------------------------------------------
module reg_file_rd_port
  import proc_pkg::*;
(
  input  logic      i_rst,
  input  reg_addr_t i_addr,
  input  logic      i_we,
  input  reg_addr_t i_waddr,
  input  word_t     i_wdata,
  input  word_t     i_regs [NREGS],
  output word_t     o_data
);

  always_comb begin
    o_data = '0;
    if (i_rst || (i_addr == ZERO_REG)) begin
      o_data = '0;
    end else if (i_we && (i_waddr == i_addr)) begin
      o_data = i_wdata;
    end else begin
      o_data = i_regs[i_addr];
    end
  end

endmodule

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// 32 x 32-bit architectural register file with one write port (writeback)
// and two combinational read ports (decode). Register 0 always reads zero.
// A same-cycle write is bypassed to the read ports, so decode sees a
// writeback result in the cycle it is written.
// Ports:
//   clk   : system clock, state updates on the rising edge
//   reset : asynchronous active-high reset, clears registers and wr_count
//   bus   : reg_file_if.slave (write port, read ports, wr_count)
// Optional build macro REG_FILE_DEBUG_PORT_EN adds:
//   dbg_addr : debug read index
//   dbg_data : committed contents of regs[dbg_addr] (no bypass), 0 for index 0
// ---------------------------------------------------------------------------
module reg_file
  import proc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  reg_file_if.slave  bus
`ifdef REG_FILE_DEBUG_PORT_EN
  ,
  input  reg_addr_t  dbg_addr,
  output word_t      dbg_data
`endif
);

  word_t       r_regs [NREGS];
  logic [15:0] r_wr_count;
  logic        w_wr_commit;

  // Writes to register 0 are dropped entirely, including the counter update.
  assign w_wr_commit = bus.RegWriteW && (bus.WriteRegW != ZERO_REG);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_count <= '0;
    end else if (w_wr_commit) begin
      r_regs[bus.WriteRegW] <= bus.ResultW;
      r_wr_count            <= r_wr_count + 16'd1;  // wraps at 0xFFFF
    end
  end

  assign bus.wr_count = r_wr_count;

  // Both ports share one implementation so they cannot diverge.
  reg_file_rd_port u_rd1 (
    .i_rst   (reset),
    .i_addr  (bus.A1),
    .i_we    (bus.RegWriteW),
    .i_waddr (bus.WriteRegW),
    .i_wdata (bus.ResultW),
    .i_regs  (r_regs),
    .o_data  (bus.RD1)
  );

  reg_file_rd_port u_rd2 (
    .i_rst   (reset),
    .i_addr  (bus.A2),
    .i_we    (bus.RegWriteW),
    .i_waddr (bus.WriteRegW),
    .i_wdata (bus.ResultW),
    .i_regs  (r_regs),
    .o_data  (bus.RD2)
  );

`ifdef REG_FILE_DEBUG_PORT_EN
  // Committed state only: no bypass from the write port.
  assign dbg_data = (dbg_addr == ZERO_REG) ? '0 : r_regs[dbg_addr];
`endif

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file of the 5-stage pipelined processor: 32 x 32-bit general-purpose registers.
- Write side is the sink of the writeback stage and accepts RegWriteW, WriteRegW and ResultW. Read side feeds the decode stage through two combinational read ports.
- Includes a write-to-read bypass, so the decode stage sees a writeback result in the same cycle it is written. No separate half-cycle write scheme is needed.
- Register $0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width.
- NREGS, 32, number of registers (2**ADDR_W).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all registers.
- RegWriteW  input  1  write enable from writeback stage.
- WriteRegW  input  ADDR_W  destination register index from writeback stage.
- ResultW  input  DATA_W  write data from writeback stage (ALUOutW or readDataW after the memToReg select).
- A1  input  ADDR_W  read port 1 index (rs) from decode.
- A2  input  ADDR_W  read port 2 index (rt) from decode.
- RD1  output  DATA_W  read port 1 data.
- RD2  output  DATA_W  read port 2 data.
- wr_count  output  16  count of committed writes to non-zero registers (debug/perf).

Behaviour:
- Reset (asynchronous, active-high):
  - On assertion, all NREGS entries go to 0 and wr_count goes to 0 immediately, with no clock required.
  - RD1/RD2 therefore read 0 while reset is high; bypass is disabled during reset.
  - A reset asserted in the same cycle as a write wins: the write is discarded.
- Write:
  - On the rising clk edge with reset low, RegWriteW=1 and WriteRegW!=0: regs[WriteRegW] <= ResultW and wr_count <= wr_count+1.
  - wr_count wraps from 0xFFFF to 0x0000.
  - Writes to index 0 are dropped and do not increment wr_count.
  - RegWriteW=0: no state change; WriteRegW and ResultW are don't-care.
- Read: combinational, zero latency. For each port n (A1->RD1, A2->RD2), evaluated independently:
  - An==0 -> 0, regardless of any write to index 0.
  - Otherwise, RegWriteW=1 and WriteRegW==An -> ResultW (write-first bypass within the same cycle).
  - Otherwise -> regs[An].
- Simultaneous events:
  - Both ports may read the same index; both return identical data, including the bypassed value.
  - A read of an index written in the previous cycle returns the stored value with no bubble.
- No X propagation: every output is defined from reset onward.
- Single write port. The writeback stage never issues two writes in one cycle, so the interface has no write arbitration.

Optional Feature:
- Macro: REG_FILE_DEBUG_PORT_EN.
- Defined: adds input dbg_addr [ADDR_W] and output dbg_data [DATA_W].
  - dbg_data returns regs[dbg_addr] with no bypass, reflecting committed state only.
  - dbg_addr==0 returns 0.
  - The testbench uses this port to check architectural state without disturbing A1/A2.
- Undefined: both ports are absent, no extra logic; read and write behaviour is otherwise identical.

Decomposition:
- Shared package proc_pkg:
  - constants DATA_W=32, ADDR_W=5, NREGS=32, ZERO_REG=5'd0;
  - typedefs reg_addr_t [ADDR_W-1:0] and word_t [DATA_W-1:0].
  - Reused by writeback, decode and hazard unit.
- One sub-module, reg_file_rd_port:
  - Implements zero-check, bypass compare and array select for one port.
  - Instantiated twice (RD1, RD2) so both ports are guaranteed identical.

Test Plan:
- Reset: assert reset mid-simulation with regs preloaded (reg5=3) -> RD1/RD2 read 0 for every A1/A2 immediately, before the next clk edge; wr_count=0.
- Basic write/read: RegWriteW=1, WriteRegW=5, ResultW=32'h3 for one cycle, then A1=5 -> RD1=3; wr_count=1.
- Bypass: RegWriteW=1, WriteRegW=7, ResultW=32'hDEADBEEF, with A1=7 and A2=7 in the same cycle -> RD1=RD2=32'hDEADBEEF before the edge; after the edge, with RegWriteW=0, both still read 32'hDEADBEEF.
- Zero register: write ResultW=32'h1 to WriteRegW=0 -> A1=0 reads 0 both same cycle and next; wr_count unchanged.
- Write disabled: RegWriteW=0, WriteRegW=5, ResultW=32'hFFFF_FFFF -> A2=5 still reads prior 3.
- Counter wrap: 65536 enabled writes to reg 1 -> wr_count returns to 0. With REG_FILE_DEBUG_PORT_EN defined, dbg_addr=1 returns the last written value and ignores a concurrent bypass.
